// File: rtl/ff_share_arbiter_if.sv
// Requester / shared flip-flop bank bus seen by ff_share_arbiter.
// FF_SHARE_LOCK_EN adds the per-requester LOCK input.
interface ff_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    logic [N_REQ-1:0]       REQ;
    logic [N_REQ*WIDTH-1:0] WDATA;
    logic [N_REQ-1:0]       GNT;
    logic [N_REQ-1:0]       ACK;
    logic [WIDTH-1:0]       D;
    logic                   WE;
    logic [WIDTH-1:0]       Q;
    logic                   BUSY;
    logic                   ERR;
`ifdef FF_SHARE_LOCK_EN
    logic [N_REQ-1:0]       LOCK;

    modport slave  (input  REQ, WDATA, Q, LOCK, output GNT, ACK, D, WE, BUSY, ERR);
    modport master (output REQ, WDATA, Q, LOCK, input  GNT, ACK, D, WE, BUSY, ERR);
`else
    modport slave  (input  REQ, WDATA, Q, output GNT, ACK, D, WE, BUSY, ERR);
    modport master (output REQ, WDATA, Q, input  GNT, ACK, D, WE, BUSY, ERR);
`endif
endinterface

// File: rtl/ff_share_arbiter.sv
// Round-robin sequencer sharing one flip-flop bank: write, settle HOLD cycles, verify Q, ack.
// Optional FF_SHARE_LOCK_EN: a locked requester is re-granted while it keeps requesting.
module ff_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 8,
    parameter int HOLD   = 2,
    parameter int INVERT = 0
) (
    input logic               CK,
    input logic               RB,
    ff_share_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_DONE} state_t;

    state_t                      state, state_n;
    logic [CNT_W-1:0]            cnt, cnt_n;
    logic [PTR_W-1:0]            ptr, ptr_n;
    logic [N_REQ-1:0]            gnt, gnt_n;
    logic [N_REQ-1:0]            ack, ack_n;
    logic [WIDTH-1:0]            d, d_n;
    logic                        we, we_n;
    logic                        err, err_n;
    logic [WIDTH-1:0]            exp_q, exp_n;
    logic [N_REQ-1:0][WIDTH-1:0] wdata_v;
    logic                        found;
    logic [PTR_W-1:0]            pick;
    logic [PTR_W-1:0]            cand;
    int                          start;
`ifdef FF_SHARE_LOCK_EN
    logic                        lock_pend, lock_n;
`endif

    assign wdata_v = bus.WDATA;

    // First requester after ptr (or at ptr when a lock is pending), wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        start = 1;
`ifdef FF_SHARE_LOCK_EN
        if (lock_pend) start = 0;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + start + k) % N_REQ);
            if (!found && bus.REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        gnt_n   = gnt;
        ack_n   = ack;
        d_n     = d;
        we_n    = we;
        err_n   = err;
        exp_n   = exp_q;
`ifdef FF_SHARE_LOCK_EN
        lock_n  = lock_pend;
`endif
        case (state)
            S_IDLE: begin
                gnt_n = '0;
                ack_n = '0;
                we_n  = 1'b0;
                if (found) begin
                    gnt_n      = '0;
                    gnt_n[pick] = 1'b1;
                    d_n        = wdata_v[pick];
                    we_n       = 1'b1;
                    ptr_n      = pick;
                    exp_n      = (INVERT != 0) ? ~wdata_v[pick] : wdata_v[pick];
                    state_n    = S_WRITE;
`ifdef FF_SHARE_LOCK_EN
                    lock_n     = 1'b0;
`endif
                end
            end
            S_WRITE: begin
                we_n    = 1'b0;
                cnt_n   = CNT_W'(HOLD - 1);
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    if (bus.Q != exp_q) err_n = 1'b1;
                    ack_n      = '0;
                    ack_n[ptr] = 1'b1;
                    state_n    = S_DONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                ack_n   = '0;
                gnt_n   = '0;
                state_n = S_IDLE;
`ifdef FF_SHARE_LOCK_EN
                lock_n  = bus.LOCK[ptr] & bus.REQ[ptr];
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RB) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= PTR_W'(N_REQ - 1);
            gnt       <= '0;
            ack       <= '0;
            d         <= '0;
            we        <= 1'b0;
            err       <= 1'b0;
            exp_q     <= '0;
`ifdef FF_SHARE_LOCK_EN
            lock_pend <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            gnt       <= gnt_n;
            ack       <= ack_n;
            d         <= d_n;
            we        <= we_n;
            err       <= err_n;
            exp_q     <= exp_n;
`ifdef FF_SHARE_LOCK_EN
            lock_pend <= lock_n;
`endif
        end
    end

    assign bus.GNT  = gnt;
    assign bus.ACK  = ack;
    assign bus.D    = d;
    assign bus.WE   = we;
    assign bus.ERR  = err;
    assign bus.BUSY = (state != S_IDLE);
endmodule

// File: tb/tb_ff_share_arbiter.sv
// Directed bench: plain and inverting-bank arbiters side by side, vector table plus
// reset/round-robin/lock sequences.
module tb_ff_share_arbiter;
    logic CK = 1'b0;
    logic RB = 1'b1;
    logic qforce = 1'b0;
    logic [7:0] bank0 = 8'h00;
    logic [7:0] bank1 = 8'h00;
    int total = 0;
    int bad = 0;
    int ack_cnt [4] = '{0, 0, 0, 0};
    int base [4];

    ff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus0 ();
    ff_share_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus1 ();

    ff_share_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(2), .INVERT(0)) dut0 (.CK(CK), .RB(RB), .bus(bus0));
    ff_share_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD(2), .INVERT(1)) dut1 (.CK(CK), .RB(RB), .bus(bus1));

    always #5 CK = ~CK;

    // Bank models: dut0 drives a plain bank, dut1 an inverting one.
    always @(posedge CK) if (bus0.WE) bank0 <= bus0.D;
    always @(posedge CK) if (bus1.WE) bank1 <= bus1.D;
    assign bus0.Q = qforce ? 8'h00 : bank0;
    assign bus1.Q = ~bank1;

    always @(negedge CK)
        for (int i = 0; i < 4; i++)
            if (bus0.ACK[i]) ack_cnt[i] <= ack_cnt[i] + 1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic        qf;
        int          g;
        logic [7:0]  d;
        logic        err;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [31:0] w);
        bus0.REQ = r;  bus1.REQ = r;
        bus0.WDATA = w; bus1.WDATA = w;
    endtask

    task automatic wait_grant(input string nm, input logic [3:0] exp);
        int n;
        n = 0;
        do begin
            @(posedge CK); #1;
            n++;
        end while (!bus0.WE && n < 40);
        chk({nm, "_seen"}, 32'(bus0.WE), 32'd1);
        chk({nm, "_gnt"}, 32'(bus0.GNT), 32'(exp));
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge CK); #1;
            n++;
        end while (bus0.BUSY && n < 40);
        chk({nm, "_idle"}, 32'(bus0.BUSY), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        logic [3:0] oh;
        oh = 4'(1 << v.g);
        @(negedge CK);
        drive(v.req, v.wdata);
        qforce = v.qf;
        @(posedge CK); #1;
        chk($sformatf("v%0d_gnt", i), 32'(bus0.GNT), 32'(oh));
        chk($sformatf("v%0d_d", i), 32'(bus0.D), 32'(v.d));
        chk($sformatf("v%0d_we", i), 32'(bus0.WE), 32'd1);
        chk($sformatf("v%0d_busy", i), 32'(bus0.BUSY), 32'd1);
        chk($sformatf("v%0d_gnt_inv", i), 32'(bus1.GNT), 32'(oh));
        // Withdraw the request and scramble data: the transaction must carry on.
        @(negedge CK);
        drive(4'b0000, 32'h0);
        @(posedge CK); #1;
        chk($sformatf("v%0d_we_off", i), 32'(bus0.WE), 32'd0);
        chk($sformatf("v%0d_d_hold", i), 32'(bus0.D), 32'(v.d));
        @(posedge CK); #1;
        chk($sformatf("v%0d_ack_early", i), 32'(bus0.ACK), 32'd0);
        @(posedge CK); #1;
        chk($sformatf("v%0d_ack", i), 32'(bus0.ACK), 32'(oh));
        chk($sformatf("v%0d_err", i), 32'(bus0.ERR), 32'(v.err));
        chk($sformatf("v%0d_ack_inv", i), 32'(bus1.ACK), 32'(oh));
        chk($sformatf("v%0d_err_inv", i), 32'(bus1.ERR), 32'd0);
        @(posedge CK); #1;
        chk($sformatf("v%0d_ack_off", i), 32'(bus0.ACK), 32'd0);
        chk($sformatf("v%0d_gnt_off", i), 32'(bus0.GNT), 32'd0);
        chk($sformatf("v%0d_idle", i), 32'(bus0.BUSY), 32'd0);
    endtask

    initial begin
        vt[0] = '{4'b0001, 32'h0000_00A5, 1'b0, 0, 8'hA5, 1'b0};
        vt[1] = '{4'b0001, 32'h0000_005A, 1'b0, 0, 8'h5A, 1'b0};
        vt[2] = '{4'b1111, 32'h4433_2211, 1'b0, 1, 8'h22, 1'b0};
        vt[3] = '{4'b1001, 32'h4433_2211, 1'b0, 3, 8'h44, 1'b0};
        vt[4] = '{4'b0110, 32'h4433_2211, 1'b0, 1, 8'h22, 1'b0};
        vt[5] = '{4'b0101, 32'h4433_2211, 1'b0, 2, 8'h33, 1'b0};
        vt[6] = '{4'b1000, 32'h4433_2211, 1'b0, 3, 8'h44, 1'b0};
        vt[7] = '{4'b0010, 32'h0000_FF00, 1'b1, 1, 8'hFF, 1'b1};
        vt[8] = '{4'b0001, 32'h0000_00C3, 1'b0, 0, 8'hC3, 1'b1};

        drive(4'b0000, 32'h0);
`ifdef FF_SHARE_LOCK_EN
        bus0.LOCK = 4'b0000;
        bus1.LOCK = 4'b0000;
`endif
        RB = 1'b1;
        repeat (2) @(posedge CK);
        #1;
        chk("rst_gnt", 32'(bus0.GNT), 32'd0);
        chk("rst_ack", 32'(bus0.ACK), 32'd0);
        chk("rst_we", 32'(bus0.WE), 32'd0);
        chk("rst_d", 32'(bus0.D), 32'd0);
        chk("rst_busy", 32'(bus0.BUSY), 32'd0);
        chk("rst_err", 32'(bus0.ERR), 32'd0);
        @(negedge CK);
        RB = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // ERR is sticky and clears only on reset.
        @(posedge CK); #1;
        chk("err_sticky", 32'(bus0.ERR), 32'd1);
        @(negedge CK);
        RB = 1'b1;
        @(posedge CK); #1;
        chk("err_clr", 32'(bus0.ERR), 32'd0);
        @(negedge CK);
        RB = 1'b0;

        // All four requesting continuously: 0,1,2,3,0 and one ACK each per round.
        base = ack_cnt;
        drive(4'b1111, 32'h4433_2211);
        wait_grant("rr0", 4'b0001);
        wait_grant("rr1", 4'b0010);
        wait_grant("rr2", 4'b0100);
        wait_grant("rr3", 4'b1000);
        wait_grant("rr4", 4'b0001);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rr_ack%0d", i), 32'(ack_cnt[i] - base[i]), 32'd1);
        @(negedge CK);
        drive(4'b0000, 32'h0);
        wait_idle("rr_end");

        // Reset in WAIT aborts without ACK and restores requester 0 priority.
        @(negedge CK);
        drive(4'b0100, 32'h0077_0000);
        @(posedge CK); #1;
        chk("abort_gnt", 32'(bus0.GNT), 32'b0100);
        @(negedge CK);
        drive(4'b0000, 32'h0);
        @(posedge CK);
        base = ack_cnt;
        @(negedge CK);
        RB = 1'b1;
        @(posedge CK); #1;
        chk("abort_gnt0", 32'(bus0.GNT), 32'd0);
        chk("abort_busy", 32'(bus0.BUSY), 32'd0);
        chk("abort_ack", 32'(bus0.ACK), 32'd0);
        @(negedge CK);
        RB = 1'b0;
        repeat (6) @(posedge CK);
        #1;
        chk("abort_noack", 32'(ack_cnt[2] - base[2]), 32'd0);
        @(negedge CK);
        drive(4'b1111, 32'h4433_2211);
        @(posedge CK); #1;
        chk("abort_next", 32'(bus0.GNT), 32'b0001);
        @(negedge CK);
        drive(4'b0000, 32'h0);
        wait_idle("abort_end");

`ifdef FF_SHARE_LOCK_EN
        @(negedge CK);
        RB = 1'b1;
        @(negedge CK);
        RB = 1'b0;
        bus0.LOCK = 4'b0001;
        bus1.LOCK = 4'b0001;
        drive(4'b0011, 32'h0000_2211);
        wait_grant("lk0", 4'b0001);
        wait_grant("lk1", 4'b0001);
        wait_grant("lk2", 4'b0001);
        @(negedge CK);
        bus0.LOCK = 4'b0000;
        bus1.LOCK = 4'b0000;
        wait_grant("lk3", 4'b0010);
        @(negedge CK);
        drive(4'b0000, 32'h0);
        wait_idle("lk_end");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
